// File: rtl/region_capture_80x40_pkg.sv
// Shared constants, FSM encoding and counter helpers for the 80x40 region capture block.
package region_capture_80x40_pkg;
   localparam int ORIGIN_X   = 39;
   localparam int ORIGIN_Y   = 39;
   localparam int WIN_W      = 80;
   localparam int WIN_H      = 40;
   localparam int WIN_PIXELS = WIN_W * WIN_H;
   localparam int ADDR_W     = 12;
   localparam int COLOUR_W   = 9;
   localparam int X_W        = 8;
   localparam int Y_W        = 7;
   localparam int RX_W       = 7;
   localparam int RY_W       = 6;
   localparam int CNT_W      = 12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction
endpackage

// File: rtl/region_capture_80x40_if.sv
// Pixel-plot input stream plus capture RAM write port and status outputs.
interface region_capture_80x40_if;
   import region_capture_80x40_pkg::*;

   logic                start;
   logic                plot;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [COLOUR_W-1:0] ram_data;
   logic                busy;
   logic                capture_done;
   logic                order_err;
   logic [CNT_W-1:0]    err_count;
   logic [CNT_W-1:0]    pix_count;

   modport master (
      output start, plot, x, y, colour,
      input  ram_we, ram_addr, ram_data, busy, capture_done, order_err, err_count, pix_count
   );

   modport slave (
      input  start, plot, x, y, colour,
      output ram_we, ram_addr, ram_data, busy, capture_done, order_err, err_count, pix_count
   );
endinterface

// File: rtl/region_addr_calc.sv
// Combinational window test and window-relative coordinates / linear RAM address.
module region_addr_calc
   import region_capture_80x40_pkg::*;
(
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   output logic              in_win,
   output logic [RX_W-1:0]   rel_x,
   output logic [RY_W-1:0]   rel_y,
   output logic [ADDR_W-1:0] addr
);
   logic [8:0] x9;
   logic [8:0] y9;

   // Bounds compared at 9 bits so ORIGIN+WIN never wraps.
   assign x9 = {1'b0, x};
   assign y9 = {2'b00, y};

   assign in_win = (x9 >= 9'(ORIGIN_X)) && (x9 < 9'(ORIGIN_X + WIN_W)) &&
                   (y9 >= 9'(ORIGIN_Y)) && (y9 < 9'(ORIGIN_Y + WIN_H));

   assign rel_x = RX_W'(x - X_W'(ORIGIN_X));
   assign rel_y = RY_W'(y - Y_W'(ORIGIN_Y));

   // rel_y*80 as (rel_y<<6) + (rel_y<<4).
   assign addr = {rel_y, 6'b0} + {2'b00, rel_y, 4'b0} + {5'b0, rel_x};
endmodule

// File: rtl/region_capture_80x40.sv
// Captures an 80x40 window of a raster pixel-plot stream into a RAM, checking raster order.
module region_capture_80x40
   import region_capture_80x40_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   region_capture_80x40_if.slave  bus
);
   state_e              state_q, state_d;
   logic [RX_W-1:0]     exp_x_q, exp_x_d;
   logic [RY_W-1:0]     exp_y_q, exp_y_d;
   logic                order_err_q, order_err_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;
   logic [CNT_W-1:0]    pix_count_q, pix_count_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [COLOUR_W-1:0] ram_data_q, ram_data_d;

   logic                in_win;
   logic [RX_W-1:0]     rel_x;
   logic [RY_W-1:0]     rel_y;
   logic [ADDR_W-1:0]   addr;

   region_addr_calc u_addr (
      .x      (bus.x),
      .y      (bus.y),
      .in_win (in_win),
      .rel_x  (rel_x),
      .rel_y  (rel_y),
      .addr   (addr)
   );

   always_comb begin
      state_d     = state_q;
      exp_x_d     = exp_x_q;
      exp_y_d     = exp_y_q;
      order_err_d = order_err_q;
      err_count_d = err_count_q;
      pix_count_d = pix_count_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;

      // start wins over plot in every state, including a restart mid-capture.
      if (bus.start) begin
         state_d     = ST_CAPTURE;
         exp_x_d     = '0;
         exp_y_d     = '0;
         order_err_d = 1'b0;
         err_count_d = '0;
         pix_count_d = '0;
      end else if (state_q == ST_CAPTURE && bus.plot) begin
         if (!in_win) begin
            err_count_d = sat_inc(err_count_q);
         end else begin
            ram_we_d    = 1'b1;
            ram_addr_d  = addr;
            ram_data_d  = bus.colour;
            pix_count_d = sat_inc(pix_count_q);
            if (rel_x != exp_x_q || rel_y != exp_y_q) begin
               order_err_d = 1'b1;
               err_count_d = sat_inc(err_count_q);
            end
            // Resync to the successor of whatever pixel actually arrived.
            if (rel_x == RX_W'(WIN_W - 1)) begin
               exp_x_d = '0;
               exp_y_d = rel_y + RY_W'(1);
            end else begin
               exp_x_d = rel_x + RX_W'(1);
            end
            if (rel_x == RX_W'(WIN_W - 1) && rel_y == RY_W'(WIN_H - 1))
               state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         exp_x_q     <= '0;
         exp_y_q     <= '0;
         order_err_q <= 1'b0;
         err_count_q <= '0;
         pix_count_q <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         exp_x_q     <= exp_x_d;
         exp_y_q     <= exp_y_d;
         order_err_q <= order_err_d;
         err_count_q <= err_count_d;
         pix_count_q <= pix_count_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
      end
   end

   assign bus.ram_we       = ram_we_q;
   assign bus.ram_addr     = ram_addr_q;
   assign bus.ram_data     = ram_data_q;
   assign bus.busy         = (state_q == ST_CAPTURE);
   assign bus.capture_done = (state_q == ST_DONE);
   assign bus.order_err    = order_err_q;
   assign bus.err_count    = err_count_q;
   assign bus.pix_count    = pix_count_q;
endmodule

// File: tb/tb_region_capture_80x40.sv
// Self-checking bench: write scoreboard, boundary vector table and multi-cycle corner sequences.
module tb_region_capture_80x40;
   import region_capture_80x40_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   region_capture_80x40_if bus();

   region_capture_80x40 dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   typedef struct {
      logic [11:0] addr;
      logic [8:0]  data;
   } wr_t;

   typedef struct {
      int   x;
      int   y;
      int   c;
      logic we;
      int   addr;
      int   err;
      int   pix;
      logic busy;
   } vec_t;

   wr_t  sb[$];
   vec_t vt[7];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_writes;
   int   last_addr;
   logic last_we;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: sample at the falling edge and match any write against the scoreboard.
   task automatic step();
      wr_t w;
      @(negedge clk);
      last_we = bus.ram_we;
      if (bus.ram_we) begin
         n_writes++;
         last_addr = int'(bus.ram_addr);
         if (sb.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            w = sb.pop_front();
            chk("wr_addr", int'(bus.ram_addr), int'(w.addr));
            chk("wr_data", int'(bus.ram_data), int'(w.data));
         end
      end else if (sb.size() != 0) begin
         chk("missing_write", 0, 1);
         sb.delete();
      end
   endtask

   task automatic drive(input logic st, input logic pl, input int x, input int y, input int c,
                        input logic exp_wr, input int exp_addr);
      bus.start  = st;
      bus.plot   = pl;
      bus.x      = 8'(x);
      bus.y      = 7'(y);
      bus.colour = 9'(c);
      if (exp_wr) sb.push_back('{addr: 12'(exp_addr), data: 9'(c)});
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
   endtask

   task automatic arm();
      drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
      step();
   endtask

   // Full raster, optionally omitting the pixel at index skip (-1 for none).
   task automatic raster(input int skip);
      for (int i = 0; i < 3200; i++) begin
         if (i == skip) continue;
         drive(1'b0, 1'b1, 39 + i % 80, 39 + i / 80, i % 512, 1'b1, i);
         step();
      end
      idle();
      step();
   endtask

   initial begin
      vt[0] = '{x: 38,  y: 39, c: 9'h011, we: 1'b0, addr: 0,    err: 1, pix: 0, busy: 1'b1};
      vt[1] = '{x: 119, y: 39, c: 9'h022, we: 1'b0, addr: 0,    err: 2, pix: 0, busy: 1'b1};
      vt[2] = '{x: 39,  y: 79, c: 9'h033, we: 1'b0, addr: 0,    err: 3, pix: 0, busy: 1'b1};
      vt[3] = '{x: 39,  y: 39, c: 9'h1FF, we: 1'b1, addr: 0,    err: 3, pix: 1, busy: 1'b1};
      vt[4] = '{x: 39,  y: 78, c: 9'h0A5, we: 1'b1, addr: 3120, err: 4, pix: 2, busy: 1'b1};
      vt[5] = '{x: 118, y: 39, c: 9'h15A, we: 1'b1, addr: 79,   err: 5, pix: 3, busy: 1'b1};
      vt[6] = '{x: 118, y: 78, c: 9'h100, we: 1'b1, addr: 3199, err: 6, pix: 4, busy: 1'b0};

      resetn = 1'b0;
      idle();
      step();
      step();
      chk("rst_ram_we",    int'(bus.ram_we), 0);
      chk("rst_busy",      int'(bus.busy), 0);
      chk("rst_done",      int'(bus.capture_done), 0);
      chk("rst_order_err", int'(bus.order_err), 0);
      chk("rst_err_count", int'(bus.err_count), 0);
      chk("rst_pix_count", int'(bus.pix_count), 0);
      chk("rst_ram_addr",  int'(bus.ram_addr), 0);
      chk("rst_ram_data",  int'(bus.ram_data), 0);
      resetn = 1'b1;

      // Full in-order raster after a one-cycle gap.
      n_writes = 0;
      arm();
      chk("t1_busy", int'(bus.busy), 1);
      idle();
      step();
      raster(-1);
      chk("t1_writes",    n_writes, 3200);
      chk("t1_last_addr", last_addr, 3199);
      chk("t1_done",      int'(bus.capture_done), 1);
      chk("t1_busy_low",  int'(bus.busy), 0);
      chk("t1_order_err", int'(bus.order_err), 0);
      chk("t1_err_count", int'(bus.err_count), 0);
      chk("t1_pix_count", int'(bus.pix_count), 3200);

      // Window boundaries and corner addresses, ending on the last pixel.
      arm();
      foreach (vt[i]) begin
         drive(1'b0, 1'b1, vt[i].x, vt[i].y, vt[i].c, vt[i].we, vt[i].addr);
         step();
         chk("tv_ram_we",    int'(last_we), int'(vt[i].we));
         chk("tv_err_count", int'(bus.err_count), vt[i].err);
         chk("tv_pix_count", int'(bus.pix_count), vt[i].pix);
         chk("tv_busy",      int'(bus.busy), int'(vt[i].busy));
         idle();
         step();
         chk("tv_we_single", int'(last_we), 0);
      end
      chk("tv_done",      int'(bus.capture_done), 1);
      chk("tv_order_err", int'(bus.order_err), 1);

      // Raster with pixel (5,0) missing: one error, then resync.
      arm();
      chk("t4_done_clr", int'(bus.capture_done), 0);
      raster(5);
      chk("t4_order_err", int'(bus.order_err), 1);
      chk("t4_err_count", int'(bus.err_count), 1);
      chk("t4_pix_count", int'(bus.pix_count), 3199);
      chk("t4_done",      int'(bus.capture_done), 1);

      // Reset in the middle of a capture.
      arm();
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 1'b1, 39 + i % 80, 39 + i / 80, i, 1'b1, i);
         step();
      end
      chk("t5_pix_before", int'(bus.pix_count), 100);
      resetn = 1'b0;
      drive(1'b0, 1'b1, 39 + 20, 40, 9'h0F0, 1'b0, 0);
      step();
      chk("t5_ram_we",    int'(last_we), 0);
      chk("t5_busy",      int'(bus.busy), 0);
      chk("t5_done",      int'(bus.capture_done), 0);
      chk("t5_pix_count", int'(bus.pix_count), 0);
      chk("t5_err_count", int'(bus.err_count), 0);
      chk("t5_order_err", int'(bus.order_err), 0);
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 39 + i, 39, i, 1'b0, 0);
         step();
         chk("t5_idle_we", int'(last_we), 0);
      end
      chk("t5_idle_pix",  int'(bus.pix_count), 0);
      chk("t5_idle_busy", int'(bus.busy), 0);

      // start with plot in IDLE, then a restart mid-capture with plot high.
      drive(1'b1, 1'b1, 39, 39, 9'h005, 1'b0, 0);
      step();
      chk("t6_busy",  int'(bus.busy), 1);
      chk("t6_pix0",  int'(bus.pix_count), 0);
      drive(1'b0, 1'b1, 39, 39, 9'h001, 1'b1, 0);
      step();
      drive(1'b0, 1'b1, 41, 39, 9'h002, 1'b1, 2);
      step();
      chk("t6_order_err_set", int'(bus.order_err), 1);
      chk("t6_err_set",       int'(bus.err_count), 1);
      chk("t6_pix_set",       int'(bus.pix_count), 2);
      drive(1'b1, 1'b1, 42, 39, 9'h007, 1'b0, 0);
      step();
      chk("t6_restart_pix",   int'(bus.pix_count), 0);
      chk("t6_restart_err",   int'(bus.err_count), 0);
      chk("t6_restart_order", int'(bus.order_err), 0);
      chk("t6_restart_busy",  int'(bus.busy), 1);
      idle();
      step();
      chk("t6_ignored_we", int'(last_we), 0);
      drive(1'b0, 1'b1, 39, 39, 9'h003, 1'b1, 0);
      step();
      chk("t6_exp_origin_order", int'(bus.order_err), 0);
      chk("t6_exp_origin_err",   int'(bus.err_count), 0);
      chk("t6_exp_origin_pix",   int'(bus.pix_count), 1);
      idle();
      step();
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
